// File: rtl/alu.sv
// alu: 32-bit registered ALU with zero/carry/negative/overflow flags
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);
  logic [32:0] sum, shl, shr;
  logic [31:0] diff, res;
  logic [4:0]  sh;
  logic        lt_s, lt_u, c_n, v_n, z_n, n_n;
  assign sh   = a[4:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign lt_u = a < b;
  assign lt_s = $signed(a) < $signed(b);
  assign shl  = {1'b0, b} << sh;
  assign shr  = {b, 1'b0} >> sh;
  assign z_n  = (aluc[3:1] == 3'b101) ? (a == b) : (res == 32'd0);
  assign n_n  = (aluc == 4'b1011) ? lt_s : res[31];
  // decode the operation into next result, carry and overflow
  always_comb begin
    res = 32'd0;
    c_n = 1'b0;
    v_n = 1'b0;
    casez (aluc)
      4'b0000: begin res = sum[31:0]; c_n = sum[32]; end
      4'b0010: begin
        res = sum[31:0];
        c_n = sum[32];
        v_n = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'b0001: begin res = diff; c_n = lt_u; end
      4'b0011: begin
        res = diff;
        c_n = lt_u;
        v_n = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      4'b0100: res = a & b;
      4'b0101: res = a | b;
      4'b0110: res = a ^ b;
      4'b0111: res = ~(a | b);
      4'b100?: res = {b[15:0], 16'h0000};
      4'b1011: res = {31'd0, lt_s};
      4'b1010: begin res = {31'd0, lt_u}; c_n = lt_u; end
      4'b1100: begin res = $signed(b) >>> sh; c_n = shr[0]; end
      4'b1101: begin res = b >> sh; c_n = shr[0]; end
      default: begin res = shl[31:0]; c_n = shl[32]; end
    endcase
  end
  // register result and flags; reset forces a clean zero result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r        <= 32'd0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r        <= res;
      zero     <= z_n;
      carry    <= c_n;
      negative <= n_n;
      overflow <= v_n;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, r;
  logic [3:0]  aluc;
  logic        zero, carry, negative, overflow;
  int checks = 0;
  int failures = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .aluc(aluc),
    .r(r), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    aluc = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(4'b0000, 32'h00000005, 32'hffff000f);
      checks++;
      if ({r, zero, carry, negative, overflow} !== {32'h0, 4'b1000}) begin
        failures++;
        $display("FAIL reset_%0d got r=%h zcnv=%b%b%b%b exp r=00000000 zcnv=1000", i, r, zero, carry, negative, overflow);
      end
    end
    rst_n = 1'b1;
    step(4'b0000, 32'h00000005, 32'hffff000f);
    checks++;
    if ({r, zero, carry, negative, overflow} !== {32'hffff0014, 4'b0010}) begin
      failures++;
      $display("FAIL reset_release got r=%h zcnv=%b%b%b%b exp r=ffff0014 zcnv=0010", r, zero, carry, negative, overflow);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  op [12] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                             4'b1000, 4'b1011, 4'b1010, 4'b1100, 4'b1101, 4'b1110};
    logic [35:0] ex [12] = '{{32'hffff0014, 4'b0010}, {32'h0000fff6, 4'b0100},
                             {32'h00000005, 4'b0000}, {32'hffff000f, 4'b0010},
                             {32'hffff000a, 4'b0010}, {32'h0000fff0, 4'b0000},
                             {32'h000f0000, 4'b0000}, {32'h00000000, 4'b0000},
                             {32'h00000001, 4'b0100}, {32'hfffff800, 4'b0010},
                             {32'h07fff800, 4'b0000}, {32'hffe001e0, 4'b0110}};
    for (int i = 0; i < 12; i++) begin
      step(op[i], 32'h00000005, 32'hffff000f);
      checks++;
      if ({r, zero, carry, negative, overflow} !== ex[i]) begin
        failures++;
        $display("FAIL op_%b got r=%h zcnv=%b%b%b%b exp r=%h zcnv=%b", op[i], r, zero, carry, negative, overflow, ex[i][35:4], ex[i][3:0]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [3:0]  op [10] = '{4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b1010,
                             4'b1111, 4'b1101, 4'b1100, 4'b0001, 4'b1001};
    logic [31:0] xa [10] = '{32'h7fffffff, 32'h7fffffff, 32'h80000000, 32'hffffffff, 32'h00001234,
                             32'h00000000, 32'hffffffe4, 32'h0000001f, 32'h00000005, 32'h0};
    logic [31:0] xb [10] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00001234,
                             32'hffff000f, 32'h80000018, 32'h80000000, 32'h00000005, 32'h1234abcd};
    logic [35:0] ex [10] = '{{32'h80000000, 4'b0011}, {32'h80000000, 4'b0010},
                             {32'h7fffffff, 4'b0001}, {32'h00000000, 4'b1100},
                             {32'h00000000, 4'b1000}, {32'hffff000f, 4'b0010},
                             {32'h08000001, 4'b0100}, {32'hffffffff, 4'b0010},
                             {32'h00000000, 4'b1000}, {32'habcd0000, 4'b0010}};
    for (int i = 0; i < 10; i++) begin
      step(op[i], xa[i], xb[i]);
      checks++;
      if ({r, zero, carry, negative, overflow} !== ex[i]) begin
        failures++;
        $display("FAIL edge_%0d_op_%b got r=%h zcnv=%b%b%b%b exp r=%h zcnv=%b", i, op[i], r, zero, carry, negative, overflow, ex[i][35:4], ex[i][3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op [6] = '{4'b0001, 4'b1110, 4'b0110, 4'b1011, 4'b1000, 4'b0000};
    logic [35:0] ex [6] = '{{32'h0000fff6, 4'b0100}, {32'hffe001e0, 4'b0110},
                            {32'hffff000a, 4'b0010}, {32'h00000000, 4'b0000},
                            {32'h000f0000, 4'b0000}, {32'hffff0014, 4'b0010}};
    a = 32'h00000005;
    b = 32'hffff000f;
    aluc = op[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({r, zero, carry, negative, overflow} !== ex[i]) begin
        failures++;
        $display("FAIL b2b_%0d got r=%h zcnv=%b%b%b%b exp r=%h zcnv=%b", i, r, zero, carry, negative, overflow, ex[i][35:4], ex[i][3:0]);
      end
      if (i < 5) begin
        aluc = op[i+1];
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 32'h0;
    b = 32'h0;
    aluc = 4'h0;
    test_reset();
    test_ops();
    test_boundaries();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  32  operand A; a[4:0] is the shift amount for shift ops.
REQ-005 b  input  32  operand B; the shifted operand for shift ops, immediate source for LUI.
REQ-006 aluc  input  4  operation select.
REQ-007 r  output  32  registered result.
REQ-008 zero  output  1  registered zero flag.
REQ-009 carry  output  1  registered carry/borrow/shift-out flag.
REQ-010 negative  output  1  registered negative flag.
REQ-011 overflow  output  1  registered signed-overflow flag.

Function
REQ-012 Inputs a, b, aluc SHALL be sampled every rising clk edge; r and all flags SHALL update on that same edge, giving 1-cycle latency, no handshake, a new operation accepted every cycle.
REQ-013 aluc decode SHALL be:
- 0000 ADDU r=a+b
- 0010 ADD r=a+b
- 0001 SUBU r=a-b
- 0011 SUB r=a-b
- 0100 AND
- 0101 OR
- 0110 XOR
- 0111 NOR
- 100x LUI r={b[15:0],16'h0}
- 1011 SLT r=(signed a<signed b)?1:0
- 1010 SLTU r=(a<b unsigned)?1:0
- 1100 SRA r=b>>>a[4:0]
- 1101 SRL r=b>>a[4:0]
- 111x SLL r=b<<a[4:0]
REQ-014 Add/sub results SHALL wrap modulo 2^32; ADD/SUB SHALL write the wrapped result even on overflow (no trap).
REQ-015 zero SHALL be (r==0) for all ops except SLT/SLTU, where zero SHALL be (a==b).
REQ-016 carry SHALL be:
- ADDU/ADD: bit-32 carry-out
- SUBU/SUB: borrow, i.e. a<b unsigned
- SLTU: a<b unsigned
- SRA/SRL: b[a[4:0]-1]
- SLL: b[32-a[4:0]]
- shift by 0: 0
- all other ops: 0
REQ-017 negative SHALL be r[31] for all ops except SLT, where negative SHALL be (signed a<signed b); for SLTU negative SHALL be 0.
REQ-018 overflow SHALL be signed overflow for ADD (operands same sign, result sign differs) and SUB (operands differ in sign, result sign differs from a); 0 for all other ops including ADDU/SUBU.
REQ-019 Shift amount SHALL use only a[4:0]; a[31:5] SHALL be ignored.
REQ-020 Output SHALL depend only on the inputs sampled at the current edge; no accumulation across cycles.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set r=0, zero=1, carry=0, negative=0, overflow=0, regardless of inputs.
REQ-022 Reset SHALL override any operation in the same cycle; the first valid result SHALL appear on the first edge with rst_n=1.
REQ-023 rst_n SHALL have no asynchronous effect; outputs SHALL hold between edges.

Verification
REQ-024 Reset: rst_n=0 for 2 edges with a=5, b=ffff000f -> r=0, zero=1, other flags 0; release -> the next edge shows the operation result.
REQ-025 With a=00000005, b=ffff000f, one op per cycle (each checked one edge later):
- ADDU -> ffff0014, carry 0, negative 1
- SUBU -> 0000fff6, carry 1
- AND -> 00000005
- OR -> ffff000f
- XOR -> ffff000a
- NOR -> 0000fff0
- LUI -> 000f0000
REQ-026 Same operands, compare and shift ops:
- SLT -> r=0, negative 0, zero 0
- SLTU -> r=1, carry 1
- SRA -> fffff800, carry 0
- SRL -> 07fff800, carry 0
- SLL -> ffe001e0, carry 1
REQ-027 Overflow cases:
- ADD a=7fffffff, b=1 -> r=80000000, overflow 1
- ADDU same operands -> overflow 0
- SUB a=80000000, b=1 -> r=7fffffff, overflow 1
REQ-028 Zero and carry boundaries:
- ADDU a=ffffffff, b=1 -> r=0, zero 1, carry 1
- SLTU a=b=1234 -> r=0, zero 1
- SLL by a=0 -> r=b, carry 0
REQ-029 Back-to-back aluc changes every cycle SHALL each produce the correct result exactly 1 cycle later, with no bubbles.
